// File: rtl/load_store_unit.sv
// Load/store unit: turns the datapath's combinational memory request into a registered
// valid/ready bus transaction and stalls the core until the access retires.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  // Datapath request
  input  logic        io_req_valid,
  input  logic        io_req_wen,
  input  logic [1:0]  io_req_size,
  input  logic [31:0] io_req_addr,
  input  logic [31:0] io_req_wdata,
  // Datapath response
  output logic        io_stall,
  output logic [3:0]  io_mask,
  output logic [31:0] io_rdata,
  output logic        io_fault,
  // Data bus
  output logic        io_bus_req_valid,
  input  logic        io_bus_req_ready,
  output logic [31:0] io_bus_req_addr,
  output logic        io_bus_req_wen,
  output logic [3:0]  io_bus_req_wstrb,
  output logic [31:0] io_bus_req_wdata,
  input  logic        io_bus_resp_valid,
  input  logic [31:0] io_bus_resp_rdata
);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StResp,
    StDone
  } state_e;

  // Last counter value at which the awaited bus event may still arrive.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic        fault_q;
  logic        bus_req_valid_q;
  logic        bus_wen_q;
  logic [3:0]  bus_wstrb_q;
  logic [31:0] bus_addr_q;
  logic [31:0] bus_wdata_q;
  logic [31:0] rdata_q;

  logic [3:0]  req_mask;
  logic        req_illegal;
  logic [31:0] req_wdata_shifted;
  logic        timeout_hit;

  // Byte-lane decode and alignment check of the incoming request.
  always_comb begin
    req_mask    = 4'b0000;
    req_illegal = 1'b0;
    unique case (io_req_size)
      2'b00: begin
        req_mask = 4'b0001 << io_req_addr[1:0];
      end
      2'b01: begin
        req_mask    = 4'b0011 << io_req_addr[1:0];
        req_illegal = io_req_addr[0];
      end
      2'b10: begin
        req_mask    = 4'b1111;
        req_illegal = |io_req_addr[1:0];
      end
      default: begin
        req_mask    = 4'b0000;
        req_illegal = 1'b1;
      end
    endcase
  end

  assign req_wdata_shifted = io_req_wdata << {io_req_addr[1:0], 3'b000};
  assign timeout_hit       = (cnt_q >= TimeoutLast);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      cnt_q           <= 8'd0;
      fault_q         <= 1'b0;
      bus_req_valid_q <= 1'b0;
      bus_wen_q       <= 1'b0;
      bus_wstrb_q     <= 4'b0000;
      bus_addr_q      <= 32'd0;
      bus_wdata_q     <= 32'd0;
      rdata_q         <= 32'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (io_req_valid && !req_illegal) begin
            state_q         <= StReq;
            cnt_q           <= 8'd0;
            fault_q         <= 1'b0;
            bus_req_valid_q <= 1'b1;
            bus_wen_q       <= io_req_wen;
            bus_wstrb_q     <= io_req_wen ? req_mask : 4'b0000;
            bus_addr_q      <= {io_req_addr[31:2], 2'b00};
            bus_wdata_q     <= req_wdata_shifted;
          end
        end
        StReq: begin
          cnt_q <= cnt_q + 8'd1;
          if (io_bus_req_ready) begin
            state_q         <= StResp;
            bus_req_valid_q <= 1'b0;
          end else if (timeout_hit) begin
            state_q         <= StDone;
            bus_req_valid_q <= 1'b0;
            fault_q         <= 1'b1;
            rdata_q         <= 32'd0;
          end
        end
        StResp: begin
          cnt_q <= cnt_q + 8'd1;
          // Store acks carry data too; it is captured regardless of direction.
          if (io_bus_resp_valid) begin
            state_q <= StDone;
            rdata_q <= io_bus_resp_rdata;
          end else if (timeout_hit) begin
            state_q <= StDone;
            fault_q <= 1'b1;
            rdata_q <= 32'd0;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign io_mask  = io_req_valid ? req_mask : 4'b0000;
  assign io_stall = io_req_valid & ~req_illegal & (state_q != StDone) & ~rst;
  // Misaligned requests retire in the cycle they are presented; bus faults retire in DONE.
  assign io_fault = ~rst & (((state_q == StDone) & fault_q) |
                            ((state_q == StIdle) & io_req_valid & req_illegal));
  assign io_rdata = rdata_q;

  assign io_bus_req_valid = bus_req_valid_q;
  assign io_bus_req_addr  = bus_addr_q;
  assign io_bus_req_wen   = bus_wen_q;
  assign io_bus_req_wstrb = bus_wstrb_q;
  assign io_bus_req_wdata = bus_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: decode vectors plus multi-cycle access sequences,
// using a second instance with a short timeout for the timeout corner case.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_wen;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        bus_req_ready;
  logic        bus_resp_valid;
  logic [31:0] bus_resp_rdata;

  logic        stall, fault, busv, bus_wen;
  logic [3:0]  mask, wstrb;
  logic [31:0] rdata, bus_addr, bus_wdata;

  logic        t_stall, t_fault, t_busv, t_bus_wen;
  logic [3:0]  t_mask, t_wstrb;
  logic [31:0] t_rdata, t_bus_addr, t_bus_wdata;

  int tests = 0;
  int fails = 0;

  load_store_unit dut (
    .clk               (clk),
    .rst               (rst),
    .io_req_valid      (req_valid),
    .io_req_wen        (req_wen),
    .io_req_size       (req_size),
    .io_req_addr       (req_addr),
    .io_req_wdata      (req_wdata),
    .io_stall          (stall),
    .io_mask           (mask),
    .io_rdata          (rdata),
    .io_fault          (fault),
    .io_bus_req_valid  (busv),
    .io_bus_req_ready  (bus_req_ready),
    .io_bus_req_addr   (bus_addr),
    .io_bus_req_wen    (bus_wen),
    .io_bus_req_wstrb  (wstrb),
    .io_bus_req_wdata  (bus_wdata),
    .io_bus_resp_valid (bus_resp_valid),
    .io_bus_resp_rdata (bus_resp_rdata)
  );

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk               (clk),
    .rst               (rst),
    .io_req_valid      (req_valid),
    .io_req_wen        (req_wen),
    .io_req_size       (req_size),
    .io_req_addr       (req_addr),
    .io_req_wdata      (req_wdata),
    .io_stall          (t_stall),
    .io_mask           (t_mask),
    .io_rdata          (t_rdata),
    .io_fault          (t_fault),
    .io_bus_req_valid  (t_busv),
    .io_bus_req_ready  (bus_req_ready),
    .io_bus_req_addr   (t_bus_addr),
    .io_bus_req_wen    (t_bus_wen),
    .io_bus_req_wstrb  (t_wstrb),
    .io_bus_req_wdata  (t_bus_wdata),
    .io_bus_resp_valid (bus_resp_valid),
    .io_bus_resp_rdata (bus_resp_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = 1'b1; req_wen = 1'b0; req_size = 2'b10; req_addr = 32'h0;
    req_wdata = 32'h0; bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_resp_rdata = 32'h0;
    @(negedge clk);
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_busv", 32'(busv), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_t_busv", 32'(t_busv), 32'd0);
    rst = 1'b0;
    req_valid = 1'b0;
  endtask

  // Minimum-latency access: ready in c1, response in c2, retire in c3.
  task automatic min_access(input string tag, input logic wen, input logic [1:0] size,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] resp, input logic [3:0] exp_mask,
                            input logic [31:0] exp_addr, input logic [3:0] exp_wstrb,
                            input logic [31:0] exp_wdata);
    @(negedge clk);
    req_valid = 1'b1; req_wen = wen; req_size = size; req_addr = addr; req_wdata = wdata;
    bus_req_ready = 1'b0; bus_resp_valid = 1'b0;
    #1;
    chk({tag, "_c0_stall"}, 32'(stall), 32'd1);
    chk({tag, "_c0_busv"}, 32'(busv), 32'd0);
    chk({tag, "_c0_mask"}, 32'(mask), 32'(exp_mask));
    @(negedge clk);
    bus_req_ready = 1'b1;
    #1;
    chk({tag, "_c1_busv"}, 32'(busv), 32'd1);
    chk({tag, "_c1_addr"}, bus_addr, exp_addr);
    chk({tag, "_c1_wen"}, 32'(bus_wen), 32'(wen));
    chk({tag, "_c1_wstrb"}, 32'(wstrb), 32'(exp_wstrb));
    chk({tag, "_c1_wdata"}, bus_wdata, exp_wdata);
    chk({tag, "_c1_stall"}, 32'(stall), 32'd1);
    @(negedge clk);
    bus_req_ready = 1'b0; bus_resp_valid = 1'b1; bus_resp_rdata = resp;
    #1;
    chk({tag, "_c2_stall"}, 32'(stall), 32'd1);
    chk({tag, "_c2_busv"}, 32'(busv), 32'd0);
    @(negedge clk);
    bus_resp_valid = 1'b0;
    #1;
    chk({tag, "_c3_stall"}, 32'(stall), 32'd0);
    chk({tag, "_c3_fault"}, 32'(fault), 32'd0);
    chk({tag, "_c3_rdata"}, rdata, resp);
  endtask

  typedef struct {
    logic        valid;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic        stall;
    logic        fault;
  } vec_t;

  vec_t vecs [10];

  initial begin
    vecs[0] = '{1'b1, 2'b10, 32'h0000_0100, 4'b1111, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 2'b00, 32'h0000_0203, 4'b1000, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 2'b00, 32'h0000_0201, 4'b0010, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 2'b01, 32'h0000_0102, 4'b1100, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 2'b01, 32'h0000_0100, 4'b0011, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 2'b01, 32'h0000_0101, 4'b0110, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 2'b10, 32'h0000_0102, 4'b1111, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 2'b10, 32'h0000_0101, 4'b1111, 1'b0, 1'b1};
    vecs[8] = '{1'b1, 2'b11, 32'h0000_0100, 4'b0000, 1'b0, 1'b1};
    vecs[9] = '{1'b0, 2'b10, 32'h0000_0100, 4'b0000, 1'b0, 1'b0};

    rst = 1'b1;
    req_valid = 1'b0; req_wen = 1'b0; req_size = 2'b00; req_addr = 32'h0; req_wdata = 32'h0;
    bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_resp_rdata = 32'h0;
    do_reset();

    // Request decode while idle; valid drops before the edge so no access starts.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req_valid = vecs[i].valid; req_wen = 1'b0; req_size = vecs[i].size;
      req_addr = vecs[i].addr;
      #1;
      chk($sformatf("vec%0d_mask", i), 32'(mask), 32'(vecs[i].mask));
      chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].stall));
      chk($sformatf("vec%0d_fault", i), 32'(fault), 32'(vecs[i].fault));
      req_valid = 1'b0;
    end

    min_access("ldw", 1'b0, 2'b10, 32'h100, 32'h0, 32'hDEAD_BEEF, 4'b1111,
               32'h100, 4'b0000, 32'h0);
    chk("ldw_t_rdata", t_rdata, 32'hDEAD_BEEF);
    @(negedge clk);
    req_valid = 1'b0;

    // Timeout on the short-timeout instance: ready never asserted.
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b0; req_size = 2'b10; req_addr = 32'h40;
    #1;
    chk("to_c0_stall", 32'(t_stall), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("to_c%0d_busv", i), 32'(t_busv), 32'd1);
      chk($sformatf("to_c%0d_stall", i), 32'(t_stall), 32'd1);
    end
    @(negedge clk);
    #1;
    chk("to_done_stall", 32'(t_stall), 32'd0);
    chk("to_done_fault", 32'(t_fault), 32'd1);
    chk("to_done_rdata", t_rdata, 32'd0);
    chk("to_done_busv", 32'(t_busv), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("to_idle_fault", 32'(t_fault), 32'd0);
    @(negedge clk);
    bus_resp_valid = 1'b1; bus_resp_rdata = 32'h1111_1111;
    @(negedge clk);
    bus_resp_valid = 1'b0;
    #1;
    chk("to_stray_rdata", t_rdata, 32'd0);

    do_reset();

    // Store byte at 0x203 with ready held low for four cycles.
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b1; req_size = 2'b00; req_addr = 32'h203;
    req_wdata = 32'h0000_00A5; bus_req_ready = 1'b0;
    #1;
    chk("stb_c0_stall", 32'(stall), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      req_wdata = 32'hFFFF_FFFF;
      #1;
      chk($sformatf("stb_c%0d_busv", i), 32'(busv), 32'd1);
      chk($sformatf("stb_c%0d_addr", i), bus_addr, 32'h200);
      chk($sformatf("stb_c%0d_wstrb", i), 32'(wstrb), 32'b1000);
      chk($sformatf("stb_c%0d_wdata", i), bus_wdata, 32'hA500_0000);
      chk($sformatf("stb_c%0d_wen", i), 32'(bus_wen), 32'd1);
      chk($sformatf("stb_c%0d_stall", i), 32'(stall), 32'd1);
    end
    @(negedge clk);
    bus_req_ready = 1'b1;
    #1;
    chk("stb_c5_busv", 32'(busv), 32'd1);
    @(negedge clk);
    bus_req_ready = 1'b0; bus_resp_valid = 1'b1; bus_resp_rdata = 32'h1234_5678;
    #1;
    chk("stb_c6_stall", 32'(stall), 32'd1);
    chk("stb_c6_busv", 32'(busv), 32'd0);
    @(negedge clk);
    bus_resp_valid = 1'b0;
    #1;
    chk("stb_c7_stall", 32'(stall), 32'd0);
    chk("stb_c7_fault", 32'(fault), 32'd0);
    chk("stb_c7_rdata", rdata, 32'h1234_5678);

    // Reset while waiting in RESP; the late response must be dropped.
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b0; req_size = 2'b10; req_addr = 32'h300;
    @(negedge clk);
    bus_req_ready = 1'b1;
    #1;
    chk("rr_req_busv", 32'(busv), 32'd1);
    @(negedge clk);
    bus_req_ready = 1'b0; rst = 1'b1;
    #1;
    chk("rr_rst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0; bus_resp_valid = 1'b1; bus_resp_rdata = 32'hCAFE_F00D;
    #1;
    chk("rr_after_busv", 32'(busv), 32'd0);
    chk("rr_after_rdata", rdata, 32'd0);
    @(negedge clk);
    bus_resp_valid = 1'b0;
    #1;
    chk("rr_late_rdata", rdata, 32'd0);

    // Misaligned half load: faults without stalling, never reaches the bus.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_valid = 1'b1; req_wen = 1'b0; req_size = 2'b01; req_addr = 32'h101;
      #1;
      chk($sformatf("mis%0d_fault", i), 32'(fault), 32'd1);
      chk($sformatf("mis%0d_stall", i), 32'(stall), 32'd0);
      chk($sformatf("mis%0d_busv", i), 32'(busv), 32'd0);
    end

    // Back-to-back stores: the second one's c0 is the single IDLE cycle between them.
    min_access("st0", 1'b1, 2'b10, 32'h0, 32'h1111_1111, 32'hA0A0_A0A0, 4'b1111,
               32'h0, 4'b1111, 32'h1111_1111);
    min_access("st4", 1'b1, 2'b10, 32'h4, 32'h2222_2222, 32'hB0B0_B0B0, 4'b1111,
               32'h4, 4'b1111, 32'h2222_2222);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("end_busv", 32'(busv), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequential load/store unit between the single-cycle datapath and the data bus. It turns the datapath's combinational memory request (address, store data, size, direction) into a registered valid/ready bus transaction. It holds the core with a stall until the response arrives, and returns the byte mask and captured read word that the datapath's load-formatting and writeback logic consume. Misaligned accesses and bus timeouts are reported as a one-cycle fault at retirement.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in REQ+RESP before the access is abandoned (legal range 1–255; counter is 8 bits).

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; one clock, synchronous, active-high
- io_req_valid  in  1  current instruction is a load or store (from control path)
- io_req_wen  in  1  1 = store, 0 = load
- io_req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
- io_req_addr  in  32  byte address (ALU output)
- io_req_wdata  in  32  store data, unshifted (rs2)
- io_stall  out  1  hold PC and register-file write
- io_mask  out  4  byte lanes of the access, to datapath load formatting
- io_rdata  out  32  captured raw bus word
- io_fault  out  1  misaligned, illegal-size or timed-out access, asserted in its retire cycle
- io_bus_req_valid  out  1  request valid
- io_bus_req_ready  in  1  bus accepts request
- io_bus_req_addr  out  32  word-aligned address {addr[31:2],2'b00}
- io_bus_req_wen  out  1  store
- io_bus_req_wstrb  out  4  store byte strobes (0000 for loads)
- io_bus_req_wdata  out  32  lane-shifted store data
- io_bus_resp_valid  in  1  response (load data or store ack)
- io_bus_resp_rdata  in  32  response data

## Operation
- **Mask**
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << addr[1:0]
  - word: 4'b1111
  - io_mask is combinational from the io_req_* inputs when io_req_valid is high, else 4'b0000.
- **Misaligned / illegal**: half with addr[0]=1, word with addr[1:0]≠0, or size 11.
  - No bus transaction is issued.
  - io_stall=0 and io_fault=1 in the same cycle; the instruction retires immediately.
- **Store data**: io_bus_req_wdata = io_req_wdata << (8·addr[1:0]), latched at request start.
- **FSM states: IDLE, REQ, RESP, DONE.**
  - IDLE: on io_req_valid with an aligned access, latch addr/wen/mask/wdata, clear the timeout counter and the fault flag, go to REQ.
  - REQ: io_bus_req_valid=1 with the latched fields held stable. On io_bus_req_ready, go to RESP.
  - RESP: on io_bus_resp_valid, capture io_bus_resp_rdata into io_rdata (captured for stores too), go to DONE.
  - DONE: io_stall=0; io_fault=fault flag. Go to IDLE unconditionally.
  - Timeout: the counter increments every cycle in REQ or RESP. When it reaches TIMEOUT_CYCLES-1 without the awaited event, go to DONE with the fault flag set and io_rdata forced to 0. io_bus_req_valid drops on entering DONE.
- **Stall**: io_stall = io_req_valid & aligned & (state≠DONE) & ~rst.
- io_bus_resp_valid is ignored in every state except RESP (late or stray responses are dropped).
- The bus never responds in the same cycle it accepts a request; the earliest response is one cycle after acceptance.

## Timing
- **Reset values**: state IDLE, io_bus_req_valid 0, io_rdata 0, io_fault 0, counter 0, io_stall 0 while rst is high.
- **Minimum access, ready and response each immediate**:
  - c0 IDLE, stall 1
  - c1 REQ, ready
  - c2 RESP, resp_valid
  - c3 DONE, stall 0, retire
  - That is 3 stall cycles per load or store.
- **Back-to-back memory instructions**: DONE→IDLE, then the next request starts. The next instruction sees 1 IDLE cycle plus its own transaction.
- **Reset mid-operation**: returns to IDLE on the next edge from any state; io_bus_req_valid is 0 from that edge; the outstanding response is ignored.
- **Timeout**: DONE is reached exactly TIMEOUT_CYCLES cycles after leaving IDLE.

## Test plan
- Load word at 0x100, ready in c1, resp 0xDEADBEEF in c2:
  - bus_addr 0x100, wstrb 0000, mask 1111
  - stall high c0–c2, low c3; io_rdata 0xDEADBEEF in c3
- Store byte 0x000000A5 at 0x203:
  - bus_addr 0x200, wstrb 1000, wdata 0xA5000000, wen 1
  - fields stable through 4 cycles with ready low; retire after ack
- Load half at 0x101:
  - io_fault 1 and io_stall 0 in the same cycle
  - io_bus_req_valid never asserts
- TIMEOUT_CYCLES=4, ready never asserted:
  - DONE 4 cycles after start, io_fault 1, io_rdata 0
  - a later resp_valid while idle is ignored
- rst asserted while in RESP:
  - next cycle IDLE, bus_req_valid 0, io_rdata 0
  - resp_valid the following cycle does not change io_rdata
- Two consecutive stores to 0x0 and 0x4, ready and response immediate:
  - two distinct bus transactions, each 3 stall cycles, one IDLE cycle between them
